// File: rtl/unidad_adelantamiento_param.sv
// rtl/unidad_adelantamiento_param.sv - parametrised forwarding and load-use hazard unit (optional macro: FWD_ZERO_REG_EN)
module unidad_adelantamiento_param #(
    parameter int REG_W    = 4,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    input  logic [NUM_SRC*REG_W-1:0] id_src,
    input  logic [REG_W-1:0]         id_dst,
    input  logic                     id_we,
    input  logic                     id_load,
    input  logic                     flush,
    output logic                     stall,
    output logic [NUM_SRC*2-1:0]     fwd_sel,
    output logic [CNT_W-1:0]         stall_cnt
);

    typedef struct packed {
        logic             valid;
        logic             we;
        logic             load;
        logic [REG_W-1:0] dst;
    } slot_t;

    slot_t            ex_q, ex_d;
    slot_t            mem_q, mem_d;
    slot_t            wb_q, wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             stall_raw;

    // A slot produces register r when it is a live instruction writing r.
    // With the zero register hardwired, r==0 never has a producer.
    function automatic logic is_prod(slot_t s, logic [REG_W-1:0] r);
        logic hit;
        hit = s.valid & s.we & (s.dst == r);
`ifdef FWD_ZERO_REG_EN
        if (r == '0) hit = 1'b0;
`endif
        return hit;
    endfunction

    // Age is the number of stages past EX; load data becomes forwardable once
    // the load is LOAD_LAT stages past EX. ALU results are always forwardable.
    function automatic logic is_ready(slot_t s, int age);
        return !s.load || (age >= LOAD_LAT);
    endfunction

    // Youngest-producer match per source: pick the mux select or flag a load-use hazard.
    always_comb begin
        stall_raw = 1'b0;
        fwd_sel   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_valid) begin
                if (is_prod(ex_q, id_src[i*REG_W +: REG_W])) begin
                    if (is_ready(ex_q, 0)) fwd_sel[2*i +: 2] = 2'b01;
                    else                   stall_raw = 1'b1;
                end else if (is_prod(mem_q, id_src[i*REG_W +: REG_W])) begin
                    if (is_ready(mem_q, 1)) fwd_sel[2*i +: 2] = 2'b10;
                    else                    stall_raw = 1'b1;
                end else if (is_prod(wb_q, id_src[i*REG_W +: REG_W])) begin
                    if (is_ready(wb_q, 2)) fwd_sel[2*i +: 2] = 2'b11;
                    else                   stall_raw = 1'b1;
                end
            end
        end
        // A taken branch squashes the decode instruction, so its hazard is moot.
        stall = stall_raw & ~flush;
    end

    // Shadow pipeline advance: bubbles on stall/flush, flush also kills the EX slot.
    always_comb begin
        ex_d = '0;
        if (id_valid && !stall && !flush) begin
            ex_d.valid = 1'b1;
            ex_d.we    = id_we;
            ex_d.load  = id_load;
            ex_d.dst   = id_dst;
`ifdef FWD_ZERO_REG_EN
            if (id_dst == '0) ex_d.we = 1'b0;
`endif
        end
        mem_d = flush ? '0 : ex_q;
        wb_d  = mem_q;
    end

    // Saturating stall cycle counter, cleared only by reset.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_unidad_adelantamiento_param.sv
// tb/tb_unidad_adelantamiento_param.sv - scoreboard bench for unidad_adelantamiento_param (LOAD_LAT=1 and LOAD_LAT=2 instances)
module tb_unidad_adelantamiento_param;

`ifdef FWD_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    typedef struct packed {
        logic       v;
        logic [3:0] s0;
        logic [3:0] s1;
        logic [3:0] dst;
        logic       we;
        logic       ld;
        logic       fl;
    } in_t;

    typedef struct packed {
        logic        stall;
        logic [3:0]  fwd;
        logic [15:0] cnt;
    } exp_t;

    typedef struct packed {
        logic [15:0] id;
        exp_t        a;
        exp_t        b;
    } pair_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    in_t         ia = '0;
    in_t         ib = '0;
    logic        a_stall, b_stall;
    logic [3:0]  a_fwd, b_fwd;
    logic [15:0] a_cnt;
    logic [1:0]  b_cnt;

    pair_t       sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          step_no = 0;

    always #5 clk = ~clk;

    unidad_adelantamiento_param #(.REG_W(4), .NUM_SRC(2), .LOAD_LAT(1), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .id_valid(ia.v), .id_src({ia.s1, ia.s0}), .id_dst(ia.dst),
        .id_we(ia.we), .id_load(ia.ld), .flush(ia.fl), .stall(a_stall), .fwd_sel(a_fwd),
        .stall_cnt(a_cnt)
    );

    unidad_adelantamiento_param #(.REG_W(4), .NUM_SRC(2), .LOAD_LAT(2), .CNT_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .id_valid(ib.v), .id_src({ib.s1, ib.s0}), .id_dst(ib.dst),
        .id_we(ib.we), .id_load(ib.ld), .flush(ib.fl), .stall(b_stall), .fwd_sel(b_fwd),
        .stall_cnt(b_cnt)
    );

    function automatic in_t I(logic v, logic [3:0] s0, logic [3:0] s1, logic [3:0] dst,
                              logic we, logic ld, logic fl);
        in_t r;
        r.v = v; r.s0 = s0; r.s1 = s1; r.dst = dst; r.we = we; r.ld = ld; r.fl = fl;
        return r;
    endfunction

    function automatic exp_t E(logic st, logic [3:0] f, logic [15:0] c);
        exp_t r;
        r.stall = st; r.fwd = f; r.cnt = c;
        return r;
    endfunction

    task automatic chk(string name, logic [15:0] id, logic [15:0] act, logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, id, act, exp);
        end
    endtask

    // Monitor: pop one expectation per cycle and compare mid-cycle.
    always @(negedge clk) begin
        pair_t p;
        if (sb.size() > 0) begin
            p = sb.pop_front();
            chk("a_stall", p.id, {15'b0, a_stall}, {15'b0, p.a.stall});
            chk("a_fwd",   p.id, {12'b0, a_fwd},   {12'b0, p.a.fwd});
            chk("a_cnt",   p.id, a_cnt,            p.a.cnt);
            chk("b_stall", p.id, {15'b0, b_stall}, {15'b0, p.b.stall});
            chk("b_fwd",   p.id, {12'b0, b_fwd},   {12'b0, p.b.fwd});
            chk("b_cnt",   p.id, {14'b0, b_cnt},   p.b.cnt);
        end
    end

    task automatic step(input logic rst, input in_t a, input in_t b, input exp_t ea, input exp_t eb);
        pair_t p;
        @(posedge clk);
        #1;
        rst_n = rst;
        ia = a;
        ib = b;
        step_no++;
        p.id = 16'(step_no); p.a = ea; p.b = eb;
        sb.push_back(p);
    endtask

    task automatic step_async_rst(input in_t a, input in_t b, input exp_t ea, input exp_t eb);
        pair_t p;
        @(posedge clk);
        #1;
        ia = a;
        ib = b;
        step_no++;
        p.id = 16'(step_no); p.a = ea; p.b = eb;
        sb.push_back(p);
        #2;
        rst_n = 1'b0;
    endtask

    initial begin
        in_t         x;
        in_t         c1, dep7, dep5, dep3, dep9;
        logic [15:0] acnt;
        x    = I(0, 0, 0, 0, 0, 0, 0);
        c1   = I(1, 7, 1, 7, 1, 0, 0);
        dep7 = I(1, 7, 1, 2, 0, 0, 0);
        dep5 = I(1, 1, 5, 2, 0, 0, 0);
        dep3 = I(1, 3, 3, 2, 0, 0, 0);
        dep9 = I(1, 9, 9, 2, 1, 0, 0);

        // Reset state and empty pipeline
        step(0, c1, x, E(0, 4'b0000, 0), E(0, 0, 0));
        step(0, c1, x, E(0, 4'b0000, 0), E(0, 0, 0));
        step(1, c1, x, E(0, 4'b0000, 0), E(0, 0, 0));
        // ALU dst=7 walks EX -> MEM -> WB -> gone
        step(1, dep7, x, E(0, 4'b0001, 0), E(0, 0, 0));
        step(1, dep7, x, E(0, 4'b0010, 0), E(0, 0, 0));
        step(1, dep7, x, E(0, 4'b0011, 0), E(0, 0, 0));
        step(1, dep7, x, E(0, 4'b0000, 0), E(0, 0, 0));
        // Load-use, LOAD_LAT=1: one stall cycle then MEM forward on src1
        step(1, I(1, 0, 0, 5, 1, 1, 0), x, E(0, 4'b0000, 0), E(0, 0, 0));
        step(1, dep5, x, E(1, 4'b0000, 0), E(0, 0, 0));
        step(1, dep5, x, E(0, 4'b1000, 1), E(0, 0, 0));
        step(1, x, x, E(0, 4'b0000, 1), E(0, 0, 0));
        // Youngest producer wins
        step(1, I(1, 0, 0, 3, 1, 0, 0), x, E(0, 4'b0000, 1), E(0, 0, 0));
        step(1, I(1, 0, 0, 3, 1, 0, 0), x, E(0, 4'b0000, 1), E(0, 0, 0));
        step(1, I(1, 3, 0, 3, 1, 0, 0), x, E(0, 4'b0001, 1), E(0, 0, 0));
        step(1, I(1, 3, 0, 3, 1, 1, 0), x, E(0, 4'b0001, 1), E(0, 0, 0));
        // Load dst=3 in EX over ALU dst=3 in MEM: stall, then both sources from MEM
        step(1, dep3, x, E(1, 4'b0000, 1), E(0, 0, 0));
        step(1, dep3, x, E(0, 4'b1010, 2), E(0, 0, 0));
        // Flush masks stall and kills the load
        step(1, I(1, 0, 0, 4, 1, 1, 0), x, E(0, 4'b0000, 2), E(0, 0, 0));
        step(1, I(1, 4, 0, 2, 0, 0, 1), x, E(0, 4'b0000, 2), E(0, 0, 0));
        step(1, I(1, 4, 0, 2, 0, 0, 0), x, E(0, 4'b0000, 2), E(0, 0, 0));
        step(1, x, x, E(0, 4'b0000, 2), E(0, 0, 0));
        // No hazard without a valid decode instruction
        step(1, I(1, 0, 0, 6, 1, 1, 0), x, E(0, 4'b0000, 2), E(0, 0, 0));
        step(1, I(0, 6, 6, 2, 0, 0, 0), x, E(0, 4'b0000, 2), E(0, 0, 0));
        // Register 0 as load destination
        step(1, I(1, 0, 0, 0, 1, 1, 0), x, E(0, 4'b0000, 2), E(0, 0, 0));
        step(1, I(1, 0, 1, 2, 0, 0, 0), x, E(!ZR, 4'b0000, 2), E(0, 0, 0));
        acnt = ZR ? 16'd2 : 16'd3;
        step(1, x, x, E(0, 4'b0000, acnt), E(0, 0, 0));
        step(1, x, x, E(0, 4'b0000, acnt), E(0, 0, 0));

        // LOAD_LAT=2 instance: two stall cycles then WB forward
        step(1, x, I(1, 0, 0, 5, 1, 1, 0), E(0, 0, acnt), E(0, 4'b0000, 0));
        step(1, x, dep5, E(0, 0, acnt), E(1, 4'b0000, 0));
        step(1, x, dep5, E(0, 0, acnt), E(1, 4'b0000, 1));
        step(1, x, dep5, E(0, 0, acnt), E(0, 4'b1100, 2));
        // Counter saturation at 2'b11
        step(1, x, I(1, 0, 0, 9, 1, 1, 0), E(0, 0, acnt), E(0, 4'b0000, 2));
        step(1, x, dep9, E(0, 0, acnt), E(1, 4'b0000, 2));
        step(1, x, dep9, E(0, 0, acnt), E(1, 4'b0000, 3));
        step(1, x, dep9, E(0, 0, acnt), E(0, 4'b1111, 3));
        // ALU results still forward from EX and MEM with LOAD_LAT=2
        step(1, x, I(1, 2, 9, 2, 0, 0, 0), E(0, 0, acnt), E(0, 4'b0001, 3));
        step(1, x, I(1, 2, 0, 2, 0, 0, 0), E(0, 0, acnt), E(0, 4'b0010, 3));
        step(1, x, x, E(0, 0, acnt), E(0, 4'b0000, 3));

        // Asynchronous reset during a load-use stall
        step(1, I(1, 0, 0, 5, 1, 1, 0), x, E(0, 4'b0000, acnt), E(0, 0, 3));
        step_async_rst(I(1, 5, 0, 2, 0, 0, 0), x, E(0, 4'b0000, 0), E(0, 0, 0));
        step(1, I(1, 5, 0, 2, 0, 0, 0), x, E(0, 4'b0000, 0), E(0, 0, 0));
        step(1, x, x, E(0, 4'b0000, 0), E(0, 0, 0));

        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
